spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter n, default 8: SPI word width (bits per frame byte).
REQ-002 SHALL have parameter aw, default n-1: register address width, taken from the command word LSBs.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port spi_out, input, n: received word from the SPI slave; valid only while spi_clko is high.
REQ-006 SHALL have port spi_clko, input, 1: word-valid strobe from the SPI slave; SCLK domain.
REQ-007 SHALL have port spi_ncs, input, 1: bus chip select, active-low; SCLK domain.
REQ-008 SHALL have port spi_in, output, n: next word to transmit on MISO.
REQ-009 SHALL have port spi_zo, output, 1: MISO Hi-Z request.
REQ-010 SHALL have port reg_addr, output, aw: register address.
REQ-011 SHALL have port reg_wdata, output, n: register write data.
REQ-012 SHALL have ports reg_we and reg_re, outputs, 1 each: one-cycle write strobe; read request held until acknowledged.
REQ-013 SHALL have ports reg_rdata (input, n) and reg_rack (input, 1): read data, qualified by the one-cycle reg_rack.
REQ-014 SHALL have ports busy (output, 1: frame in progress) and err (output, 1: sticky read-underrun flag).

Function
REQ-015 SHALL synchronize spi_clko and spi_ncs through 2 flops, then edge-detect; a spi_clko rise is acted on at the 3rd clk edge after the input rises.
REQ-016 SHALL capture spi_out on the cycle a spi_clko rise is detected; clk is at least 16x SCLK.
REQ-017 SHALL implement the FSM states IDLE, CMD, WDATA, RFETCH and RDATA.
REQ-018 SHALL move IDLE->CMD on a synced spi_ncs fall; busy=1 in every state except IDLE.
REQ-019 SHALL decode the CMD word as bit n-1 = rw (1 = read) and bits aw-1:0 = addr; it loads reg_addr, then goes to WDATA if rw=0, else RFETCH.
REQ-020 SHALL, for each WDATA word, drive reg_wdata=word and pulse reg_we for exactly 1 cycle, 1 cycle after capture; it then increments reg_addr.
REQ-021 SHALL, in RFETCH, assert reg_re until reg_rack; it then loads spi_in=reg_rdata, clears spi_zo, goes to RDATA and increments reg_addr.
REQ-022 SHALL, in RDATA, return to RFETCH on each detected spi_clko fall to prefetch the next word.
REQ-023 SHALL, if a spi_clko fall is detected while in RFETCH, set err, drive spi_in=all-ones, and keep waiting for reg_rack.
REQ-024 SHALL, at frame start, hold spi_in={err, n-1 zeros} with spi_zo=1; outside read frames spi_zo=1.
REQ-025 SHALL, on a synced spi_ncs rise in any state, go to IDLE next cycle, drop reg_re, set spi_zo=1 and spi_in={err,0..}; a pending reg_rack is ignored.
REQ-026 SHALL wrap reg_addr modulo 2^aw on increment (all-ones -> 0).
REQ-027 SHALL clear err only by rst.
REQ-028 SHALL give simultaneous ncs-rise and clko-edge detection precedence to ncs; the word is discarded.

Reset
REQ-029 SHALL, on rst, set state=IDLE, spi_in=0, spi_zo=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err=0 and clear the synchronizer flops.
REQ-030 SHALL, after rst is released mid-frame, stay in IDLE until a fresh synced spi_ncs fall; it ignores words of the interrupted frame.

Configuration
REQ-031 SHALL, with SPI_REG_CTRL_AUTOINC_EN defined, increment reg_addr per REQ-020/021/026.
REQ-032 SHALL, without SPI_REG_CTRL_AUTOINC_EN, hold reg_addr at the CMD address for the whole frame (FIFO-style register access).

Structure
REQ-033 SHALL place the state encodings, the rw bit index (n-1) and the underrun fill value in a shared include file spi_reg_defs.
REQ-034 SHALL implement the synchronizer plus rise/fall detector as sub-module sync_edge, instantiated once per spi_clko and once per spi_ncs.

Verification
REQ-035 SHALL cover a write: frame 0x05,0xA1,0xB2 -> reg_we pulses with (addr 5, 0xA1) then (addr 6, 0xB2); exactly 2 pulses.
REQ-036 SHALL cover a read: frame 0x83 plus 2 dummy words, reg_rack 1 cycle after reg_re with rdata 0x3C then 0x4D -> MISO words 0x00,0x3C,0x4D; spi_zo=0 after word 0.
REQ-037 SHALL cover an underrun: read frame with reg_rack withheld past the clko fall -> that word 0xFF, err=1; the next frame's first MISO word is 0x80.
REQ-038 SHALL cover wrap: write to addr 0x7F with 2 data words -> addresses 0x7F then 0x00; without SPI_REG_CTRL_AUTOINC_EN -> 0x7F twice.
REQ-039 SHALL cover mid-frame abort: spi_ncs raised after the CMD word -> IDLE within 4 cycles, reg_re=0, spi_zo=1, no reg_we.
REQ-040 SHALL cover rst during WDATA: the remaining words produce no reg_we; the next frame after ncs cycling is decoded normally.

Source files
------------

// File: rtl/spi_reg_defs.sv
// Shared definitions for the SPI register controller: FSM encodings, the
// command rw-bit position and the MISO fill value used on a read underrun.
package spi_reg_defs;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_WDATA  = 3'd2,
      ST_RFETCH = 3'd3,
      ST_RDATA  = 3'd4
   } state_t;

   // Every bit of the MISO word is driven to this value when read data is late.
   localparam logic UNDERRUN_FILL_BIT = 1'b1;

   function automatic int rw_bit_idx(input int width);
      return width - 1;
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Two-flop synchronizer for an SCLK-domain level followed by a rise/fall
// detector; an input edge shows up as a one-cycle pulse two clk edges later.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI-slave-to-register-bus bridge: command word selects address and direction,
// then streams writes or prefetched reads. SPI_REG_CTRL_AUTOINC_EN enables address auto-increment.
module spi_reg_ctrl
   import spi_reg_defs::*;
#(
   parameter int n  = 8,
   parameter int aw = n - 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [n-1:0]  spi_out,
   input  logic          spi_clko,
   input  logic          spi_ncs,
   output logic [n-1:0]  spi_in,
   output logic          spi_zo,
   output logic [aw-1:0] reg_addr,
   output logic [n-1:0]  reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [n-1:0]  reg_rdata,
   input  logic          reg_rack,
   output logic          busy,
   output logic          err
);

   localparam int RW_BIT = rw_bit_idx(n);
   localparam logic [n-1:0] FILL_WORD = {n{UNDERRUN_FILL_BIT}};

   state_t        state_q, state_d;
   logic [n-1:0]  spi_in_q, spi_in_d;
   logic          spi_zo_q, spi_zo_d;
   logic [aw-1:0] reg_addr_q, reg_addr_d;
   logic [n-1:0]  reg_wdata_q, reg_wdata_d;
   logic          reg_we_q, reg_we_d;
   logic          reg_re_q, reg_re_d;
   logic          err_q, err_d;

   logic          clko_rise, clko_fall;
   logic          ncs_rise, ncs_fall;
   logic [aw-1:0] addr_inc;
   logic [n-1:0]  idle_word;

   sync_edge u_clko_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_clko),
      .rise (clko_rise),
      .fall (clko_fall)
   );

   sync_edge u_ncs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_ncs),
      .rise (ncs_rise),
      .fall (ncs_fall)
   );

   always_comb begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
      addr_inc = reg_addr_q + 1'b1;
`else
      addr_inc = reg_addr_q;
`endif
   end

   assign idle_word = {err_q, {(n-1){1'b0}}};

   always_comb begin
      state_d     = state_q;
      spi_in_d    = spi_in_q;
      spi_zo_d    = spi_zo_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = reg_re_q;
      err_d       = err_q;

      // Step the address only once the write strobe has been seen with the old one.
      if (reg_we_q) begin
         reg_addr_d = addr_inc;
      end

      if (ncs_rise) begin
         state_d  = ST_IDLE;
         reg_re_d = 1'b0;
         spi_zo_d = 1'b1;
         spi_in_d = idle_word;
      end else begin
         case (state_q)
            ST_IDLE: begin
               spi_in_d = idle_word;
               spi_zo_d = 1'b1;
               reg_re_d = 1'b0;
               if (ncs_fall) begin
                  state_d = ST_CMD;
               end
            end
            ST_CMD: begin
               if (clko_rise) begin
                  reg_addr_d = spi_out[aw-1:0];
                  if (spi_out[RW_BIT]) begin
                     state_d  = ST_RFETCH;
                     reg_re_d = 1'b1;
                  end else begin
                     state_d = ST_WDATA;
                  end
               end
            end
            ST_WDATA: begin
               if (clko_rise) begin
                  reg_wdata_d = spi_out;
                  reg_we_d    = 1'b1;
               end
            end
            ST_RFETCH: begin
               reg_re_d = 1'b1;
               if (reg_re_q && reg_rack) begin
                  spi_in_d   = reg_rdata;
                  spi_zo_d   = 1'b0;
                  reg_re_d   = 1'b0;
                  reg_addr_d = addr_inc;
                  state_d    = ST_RDATA;
               end else if (clko_fall) begin
                  // The slave has already moved on to the next word: flag the underrun.
                  err_d    = 1'b1;
                  spi_in_d = FILL_WORD;
               end
            end
            ST_RDATA: begin
               if (clko_fall) begin
                  state_d  = ST_RFETCH;
                  reg_re_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         spi_in_q    <= '0;
         spi_zo_q    <= 1'b1;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         spi_in_q    <= spi_in_d;
         spi_zo_q    <= spi_zo_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         err_q       <= err_d;
      end
   end

   assign spi_in    = spi_in_q;
   assign spi_zo    = spi_zo_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign reg_re    = reg_re_q;
   assign busy      = (state_q != ST_IDLE);
   assign err       = err_q;

endmodule
